// File: rtl/segre_pkg.sv
// Shared types and constants for the segre memory subsystem.
package segre_pkg;

  localparam int unsigned WORD_SIZE = 32;
  localparam int unsigned ADDR_SIZE = 32;

  // Consecutive data grants tolerated while fetch waits (1..15).
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } memop_data_type_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY_IF   = 2'd1,
    BUSY_DATA = 2'd2,
    MISALIGN  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/segre_mem_arbiter_if.sv
// Requester and memory-side signals of the memory arbiter.
// slave: the arbiter's view. master: the environment (requesters + memory).
interface segre_mem_arbiter_if;
  import segre_pkg::*;

  logic                   if_req_i;
  logic [ADDR_SIZE-1:0]   if_addr_i;
  logic                   if_gnt_o;
  logic                   if_rvalid_o;
  logic [WORD_SIZE-1:0]   if_rdata_o;

  logic                   mem_rd_i;
  logic                   mem_wr_i;
  memop_data_type_e       mem_type_i;
  logic [ADDR_SIZE-1:0]   mem_addr_i;
  logic [WORD_SIZE-1:0]   mem_wdata_i;
  logic                   mem_gnt_o;
  logic                   mem_rvalid_o;
  logic [WORD_SIZE-1:0]   mem_rdata_o;
  logic                   mem_misalign_o;

  logic                   m_req_o;
  logic                   m_we_o;
  logic [ADDR_SIZE-1:0]   m_addr_o;
  logic [3:0]             m_be_o;
  logic [WORD_SIZE-1:0]   m_wdata_o;
  logic                   m_ready_i;
  logic [WORD_SIZE-1:0]   m_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  mem_rd_i, mem_wr_i, mem_type_i, mem_addr_i, mem_wdata_i,
    output mem_gnt_o, mem_rvalid_o, mem_rdata_o, mem_misalign_o,
    output m_req_o, m_we_o, m_addr_o, m_be_o, m_wdata_o,
    input  m_ready_i, m_rdata_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output mem_rd_i, mem_wr_i, mem_type_i, mem_addr_i, mem_wdata_i,
    input  mem_gnt_o, mem_rvalid_o, mem_rdata_o, mem_misalign_o,
    input  m_req_o, m_we_o, m_addr_o, m_be_o, m_wdata_o,
    output m_ready_i, m_rdata_i
  );

endinterface

// File: rtl/segre_mem_be_gen.sv
// Byte-enable / write-data lane generation and alignment check for data accesses.
module segre_mem_be_gen
  import segre_pkg::*;
(
  input  memop_data_type_e      i_type,
  input  logic [1:0]            i_addr_lo,
  input  logic [WORD_SIZE-1:0]  i_wdata,
  output logic [3:0]            o_be,
  output logic [WORD_SIZE-1:0]  o_wdata,
  output logic                  o_misalign
);

  // Replicate right-aligned store data across lanes; enable only the addressed lanes.
  always_comb begin
    o_be       = 4'b1111;
    o_wdata    = i_wdata;
    o_misalign = 1'b0;
    unique case (i_type)
      BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      HALF: begin
        o_be       = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata    = {2{i_wdata[15:0]}};
        o_misalign = i_addr_lo[0];
      end
      WORD: begin
        o_misalign = |i_addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/segre_mem_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single-port variable-latency memory.
// Fetch is protected from starvation by a saturating count of data wins it sat through.
module segre_mem_arbiter
  import segre_pkg::*;
#(
  parameter int unsigned WORD_SIZE    = segre_pkg::WORD_SIZE,
  parameter int unsigned ADDR_SIZE    = segre_pkg::ADDR_SIZE,
  parameter int unsigned STARVE_LIMIT = segre_pkg::STARVE_LIMIT_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  segre_mem_arbiter_if.slave bus
);

  arb_state_e             r_state;
  arb_state_e             w_next;
  logic [3:0]             r_starve_cnt;
  logic                   r_m_req;
  logic                   r_m_we;
  logic [ADDR_SIZE-1:0]   r_m_addr;
  logic [3:0]             r_m_be;
  logic [WORD_SIZE-1:0]   r_m_wdata;

  logic                   w_data_req;
  logic                   w_starved;
  logic                   w_fetch_win;
  logic                   w_data_win;
  logic [3:0]             w_be;
  logic [WORD_SIZE-1:0]   w_wdata;
  logic                   w_misalign;

  segre_mem_be_gen u_be_gen (
    .i_type     (bus.mem_type_i),
    .i_addr_lo  (bus.mem_addr_i[1:0]),
    .i_wdata    (bus.mem_wdata_i),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_misalign (w_misalign)
  );

  // Grants are only decided in IDLE and never while reset is asserted.
  assign w_data_req  = bus.mem_rd_i | bus.mem_wr_i;
  assign w_starved   = (r_starve_cnt == 4'(STARVE_LIMIT));
  assign w_fetch_win = (r_state == IDLE) && !rst_i && bus.if_req_i && (!w_data_req || w_starved);
  assign w_data_win  = (r_state == IDLE) && !rst_i && w_data_req && !w_fetch_win;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state: one grant per IDLE visit, return to IDLE on completion.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_fetch_win)     w_next = BUSY_IF;
        else if (w_data_win) w_next = w_misalign ? MISALIGN : BUSY_DATA;
      end
      BUSY_IF, BUSY_DATA: begin
        if (bus.m_ready_i) w_next = IDLE;
      end
      MISALIGN: w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Requester-side outputs: combinational grants, responses and misalign flag.
  always_comb begin
    bus.if_gnt_o       = 1'b0;
    bus.if_rvalid_o    = 1'b0;
    bus.if_rdata_o     = '0;
    bus.mem_gnt_o      = 1'b0;
    bus.mem_rvalid_o   = 1'b0;
    bus.mem_rdata_o    = '0;
    bus.mem_misalign_o = 1'b0;
    if (!rst_i) begin
      unique case (r_state)
        IDLE: begin
          bus.if_gnt_o  = w_fetch_win;
          bus.mem_gnt_o = w_data_win;
        end
        BUSY_IF: begin
          if (bus.m_ready_i) begin
            bus.if_rvalid_o = 1'b1;
            bus.if_rdata_o  = bus.m_rdata_i;
          end
        end
        BUSY_DATA: begin
          if (bus.m_ready_i) begin
            bus.mem_rvalid_o = 1'b1;
            bus.mem_rdata_o  = r_m_we ? '0 : bus.m_rdata_i;
          end
        end
        MISALIGN: begin
          bus.mem_rvalid_o   = 1'b1;
          bus.mem_misalign_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Starvation counter: data wins over a waiting fetch count up, any fetch win clears.
  always_ff @(posedge clk_i) begin
    if (rst_i)                                        r_starve_cnt <= '0;
    else if (w_fetch_win)                             r_starve_cnt <= '0;
    else if (w_data_win && bus.if_req_i && !w_starved) r_starve_cnt <= r_starve_cnt + 4'd1;
  end

  // Memory request registers: latched at grant, held until the memory completes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_m_req   <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_be    <= '0;
      r_m_wdata <= '0;
    end else if (w_fetch_win) begin
      r_m_req   <= 1'b1;
      r_m_we    <= 1'b0;
      r_m_addr  <= bus.if_addr_i & ~ADDR_SIZE'(3);
      r_m_be    <= 4'b1111;
      r_m_wdata <= '0;
    end else if (w_data_win && !w_misalign) begin
      r_m_req   <= 1'b1;
      r_m_we    <= bus.mem_wr_i;
      r_m_addr  <= bus.mem_addr_i & ~ADDR_SIZE'(3);
      r_m_be    <= w_be;
      r_m_wdata <= w_wdata;
    end else if (r_m_req && bus.m_ready_i) begin
      r_m_req   <= 1'b0;
    end
  end

  assign bus.m_req_o   = r_m_req;
  assign bus.m_we_o    = r_m_we;
  assign bus.m_addr_o  = r_m_addr;
  assign bus.m_be_o    = r_m_be;
  assign bus.m_wdata_o = r_m_wdata;

  // Load and store raised together is a requester bug; it is issued as a store.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_data_win)
      assert (!(bus.mem_rd_i && bus.mem_wr_i))
        else $warning("segre_mem_arbiter: load and store requested together, issued as store");
  end

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Bench for segre_mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a transaction-level model.
module tb_segre_mem_arbiter;
  import segre_pkg::*;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  segre_mem_arbiter_if bus ();

  segre_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit model_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: at most one outstanding access plus a starvation tally.
  bit          t_active = 1'b0;
  bit          t_fetch, t_misal, t_we;
  logic [31:0] t_addr, t_wdata;
  logic [3:0]  t_be;
  int          starve = 0;

  logic        e_ifg, e_mg, e_ifrv, e_mrv, e_mis, e_req, dreq, fwin, dwin;
  int unsigned off;

  always @(negedge clk) begin
    if (model_on) begin
      e_ifg = 0; e_mg = 0; e_ifrv = 0; e_mrv = 0; e_mis = 0;
      fwin = 0; dwin = 0;
      dreq = bus.mem_rd_i | bus.mem_wr_i;
      if (!rst) begin
        if (!t_active) begin
          fwin  = bus.if_req_i && (!dreq || starve == LIMIT);
          dwin  = dreq && !fwin;
          e_ifg = fwin;
          e_mg  = dwin;
        end else if (t_misal) begin
          e_mrv = 1; e_mis = 1;
        end else if (bus.m_ready_i) begin
          if (t_fetch) e_ifrv = 1;
          else         e_mrv  = 1;
        end
      end
      e_req = t_active && !t_misal;

      chk("if_gnt", bus.if_gnt_o, e_ifg);
      chk("mem_gnt", bus.mem_gnt_o, e_mg);
      chk("if_rvalid", bus.if_rvalid_o, e_ifrv);
      chk("mem_rvalid", bus.mem_rvalid_o, e_mrv);
      chk("mem_misalign", bus.mem_misalign_o, e_mis);
      chk("m_req", bus.m_req_o, e_req);
      if (e_ifrv) chk("if_rdata", bus.if_rdata_o, bus.m_rdata_i);
      if (e_mrv && !e_mis) chk("mem_rdata", bus.mem_rdata_o, t_we ? 32'd0 : bus.m_rdata_i);
      if (e_req) begin
        chk("m_we", bus.m_we_o, t_we);
        chk("m_addr", bus.m_addr_o, t_addr);
        chk("m_be", bus.m_be_o, t_be);
        if (t_we) chk("m_wdata", bus.m_wdata_o, t_wdata);
      end

      // advance the model to the state after the coming rising edge
      if (rst) begin
        t_active = 0;
        starve   = 0;
      end else if (!t_active) begin
        if (fwin) begin
          t_active = 1; t_fetch = 1; t_misal = 0; t_we = 0;
          t_addr = bus.if_addr_i - (bus.if_addr_i % 4);
          t_be = 4'hF;
          starve = 0;
        end else if (dwin) begin
          t_active = 1; t_fetch = 0;
          t_we   = bus.mem_wr_i;
          off    = bus.mem_addr_i % 4;
          t_addr = bus.mem_addr_i - off;
          case (bus.mem_type_i)
            BYTE: begin
              t_be = 4'(1 << off);
              t_wdata = (bus.mem_wdata_i & 32'hFF) * 32'h01010101;
              t_misal = 0;
            end
            HALF: begin
              t_be = 4'(3 << (off & 2));
              t_wdata = (bus.mem_wdata_i & 32'hFFFF) * 32'h00010001;
              t_misal = (off % 2) != 0;
            end
            default: begin
              t_be = 4'hF;
              t_wdata = bus.mem_wdata_i;
              t_misal = off != 0;
            end
          endcase
          if (bus.if_req_i && starve < LIMIT) starve++;
        end
      end else if (t_misal || bus.m_ready_i) begin
        t_active = 0;
      end
    end
  end

  // Collect grant letters (D = data, F = fetch) with current inputs held.
  task automatic collect(input int n, output string seq);
    seq = "";
    for (int c = 0; c < 40 && seq.len() < n; c++) begin
      @(negedge clk);
      if (bus.if_gnt_o)  seq = {seq, "F"};
      if (bus.mem_gnt_o) seq = {seq, "D"};
      tick();
    end
  endtask

  string seq;
  logic  g_if, g_m;
  int    r;

  initial begin
    bus.if_req_i = 0; bus.if_addr_i = 0;
    bus.mem_rd_i = 0; bus.mem_wr_i = 0; bus.mem_type_i = WORD;
    bus.mem_addr_i = 0; bus.mem_wdata_i = 0;
    bus.m_ready_i = 0; bus.m_rdata_i = 0;

    repeat (2) tick();
    model_on = 1;
    tick();
    rst = 0;

    // reset state
    @(negedge clk);
    chk("rst m_req", bus.m_req_o, 0);
    chk("rst m_we", bus.m_we_o, 0);
    chk("rst m_addr", bus.m_addr_o, 0);
    chk("rst m_be", bus.m_be_o, 0);
    chk("rst m_wdata", bus.m_wdata_o, 0);
    chk("rst if_gnt", bus.if_gnt_o, 0);
    chk("rst mem_gnt", bus.mem_gnt_o, 0);

    // fetch 0x100, memory ready three cycles after the grant
    tick();
    bus.if_req_i = 1; bus.if_addr_i = 32'h100;
    @(negedge clk);
    chk("fetch gnt", bus.if_gnt_o, 1);
    tick();
    bus.if_req_i = 0;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) tick();
      if (k == 3) begin bus.m_ready_i = 1; bus.m_rdata_i = 32'hDEADBEEF; end
      @(negedge clk);
      chk("fetch m_req", bus.m_req_o, 1);
      chk("fetch m_addr", bus.m_addr_o, 32'h100);
      chk("fetch m_be", bus.m_be_o, 4'hF);
      chk("fetch if_rvalid", bus.if_rvalid_o, k == 3);
      if (k == 3) chk("fetch if_rdata", bus.if_rdata_o, 32'hDEADBEEF);
    end
    tick();
    bus.m_ready_i = 0;

    // store byte at 0x203
    bus.mem_wr_i = 1; bus.mem_type_i = BYTE; bus.mem_addr_i = 32'h203; bus.mem_wdata_i = 32'h000000AB;
    @(negedge clk);
    chk("sb gnt", bus.mem_gnt_o, 1);
    tick();
    bus.mem_wr_i = 0; bus.m_ready_i = 1; bus.m_rdata_i = 32'h13572468;
    @(negedge clk);
    chk("sb m_be", bus.m_be_o, 4'b1000);
    chk("sb m_wdata", bus.m_wdata_o, 32'hABABABAB);
    chk("sb m_addr", bus.m_addr_o, 32'h200);
    chk("sb m_we", bus.m_we_o, 1);
    chk("sb mem_rvalid", bus.mem_rvalid_o, 1);
    tick();
    bus.m_ready_i = 0;

    // misaligned half load at 0x101
    bus.mem_rd_i = 1; bus.mem_type_i = HALF; bus.mem_addr_i = 32'h101;
    @(negedge clk);
    chk("lh gnt", bus.mem_gnt_o, 1);
    tick();
    bus.mem_rd_i = 0;
    @(negedge clk);
    chk("lh rvalid", bus.mem_rvalid_o, 1);
    chk("lh misalign", bus.mem_misalign_o, 1);
    chk("lh m_req", bus.m_req_o, 0);
    tick();

    // continuous contention: fetch gets through after LIMIT data grants
    bus.if_req_i = 1; bus.if_addr_i = 32'h40;
    bus.mem_rd_i = 1; bus.mem_type_i = WORD; bus.mem_addr_i = 32'h80;
    bus.m_ready_i = 1;
    collect(10, seq);
    chk_str("starve order", seq, "DDDDFDDDDF");
    @(negedge clk);                 // fetch completes
    tick();

    // reset while a data access is in flight, with the memory responding that cycle
    bus.m_ready_i = 0;
    @(negedge clk);
    chk("pre-rst mem_gnt", bus.mem_gnt_o, 1);
    tick();
    tick();
    rst = 1; bus.m_ready_i = 1;
    @(negedge clk);
    chk("rst mem_rvalid", bus.mem_rvalid_o, 0);
    chk("rst if_rvalid", bus.if_rvalid_o, 0);
    tick();
    rst = 0;
    chk("post-rst m_req", bus.m_req_o, 0);
    collect(5, seq);
    chk_str("post-rst order", seq, "DDDDF");
    bus.if_req_i = 0; bus.mem_rd_i = 0;
    @(negedge clk);
    tick();
    bus.m_ready_i = 0;

    // load and store together: issued as a store
    bus.mem_rd_i = 1; bus.mem_wr_i = 1; bus.mem_type_i = WORD;
    bus.mem_addr_i = 32'h300; bus.mem_wdata_i = 32'h12345678;
    @(negedge clk);
    chk("rdwr gnt", bus.mem_gnt_o, 1);
    tick();
    bus.mem_rd_i = 0; bus.mem_wr_i = 0; bus.m_ready_i = 1; bus.m_rdata_i = 32'hFFFF0000;
    @(negedge clk);
    chk("rdwr m_we", bus.m_we_o, 1);
    chk("rdwr m_wdata", bus.m_wdata_o, 32'h12345678);
    chk("rdwr rdata", bus.mem_rdata_o, 0);
    tick();
    bus.m_ready_i = 0;

    // randomized traffic; requesters hold until granted
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g_if = bus.if_gnt_o;
      g_m  = bus.mem_gnt_o;
      tick();
      if (!bus.if_req_i || g_if) begin
        bus.if_req_i  = ($urandom_range(0, 99) < 55);
        bus.if_addr_i = $urandom;
      end
      if (!(bus.mem_rd_i || bus.mem_wr_i) || g_m) begin
        r = $urandom_range(0, 99);
        bus.mem_rd_i    = (r < 30) || (r >= 98);
        bus.mem_wr_i    = (r >= 30 && r < 60) || (r >= 98);
        bus.mem_type_i  = memop_data_type_e'($urandom_range(0, 2));
        bus.mem_addr_i  = $urandom;
        bus.mem_wdata_i = $urandom;
      end
      bus.m_ready_i = ($urandom_range(0, 99) < 45);
      bus.m_rdata_i = $urandom;
      rst = ($urandom_range(0, 249) == 0);
    end
    rst = 0;
    bus.if_req_i = 0; bus.mem_rd_i = 0; bus.mem_wr_i = 0; bus.m_ready_i = 1;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
